fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 82 ++++++++
 rtl/fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch-stage types: buffer entry struct and PC step helper
package fetch_unit_pkg;

  localparam int unsigned RV32_INST_BYTES = 4;

  // One buffered instruction together with the address it was fetched from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } rv32_fetch_entry;

  // Sequential next-fetch address; wraps modulo 2^32
  function automatic logic [31:0] rv32_next_pc(input logic [31:0] pc);
    return pc + 32'(RV32_INST_BYTES);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetch entries with push/pop/flush and occupancy count
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_flush,
  input  logic                           i_push,
  input  rv32_fetch_entry                i_wdata,
  input  logic                           i_pop,
  output rv32_fetch_entry                o_rdata,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  rv32_fetch_entry mem_q [DEPTH];
  rv32_fetch_entry mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_rdata = mem_q[rd_ptr_q];

  // Full/empty guards keep pointers coherent even if a caller misbehaves
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  // Next-state for storage, pointers and count; flush discards everything
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = i_wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CW'(1);
      end else if (!do_push && do_pop) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // Pointer and count registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless while the count says empty
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage; define FETCH_MISALIGN_CHECK_EN for misaligned-redirect faults
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_addr,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_fault,
  output logic [31:0] o_fault_addr
);

  localparam int unsigned    CW          = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]    DEPTH_LIMIT = (CW+1)'(FIFO_DEPTH);

  logic [31:0]     pc_q, pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;

  logic            grant, resp_keep, pop;
  logic            fault_now;
  logic [31:0]     redirect_pc;
  logic [CW:0]     credit_used;

  rv32_fetch_entry fifo_wdata, fifo_rdata;
  rv32_fetch_entry pcq_wdata, pcq_rdata;
  logic            fifo_full, fifo_empty, pcq_full, pcq_empty;
  logic [CW-1:0]   fifo_count, pcq_count;
  logic            unused_ok;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  assign redirect_pc  = i_branch_addr;
  assign fault_now    = fault_q;
  assign o_fault      = fault_q;
  assign o_fault_addr = fault_addr_q;

  // Every redirect re-judges the fault against its own target
  always_comb begin
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    if (i_branch_taken) begin
      fault_d      = |i_branch_addr[1:0];
      fault_addr_d = (|i_branch_addr[1:0]) ? i_branch_addr : '0;
    end
  end

  // Fault flag and captured target
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end
`else
  assign redirect_pc  = {i_branch_addr[31:2], 2'b00};
  assign fault_now    = 1'b0;
  assign o_fault      = 1'b0;
  assign o_fault_addr = '0;
`endif

  // A head popped this cycle frees its slot for a same-cycle request,
  // which is what sustains one fetch per cycle with a two-entry buffer.
  assign pop         = !fifo_empty && i_inst_ready;
  assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count} - (CW+1)'(pop);

  assign o_imem_req  = !i_branch_taken && !fault_now && (credit_used < DEPTH_LIMIT);
  assign o_imem_addr = pc_q;
  assign grant       = o_imem_req && i_imem_gnt;
  assign resp_keep   = i_imem_rvalid && (discard_q == '0);

  assign o_inst_valid = !fifo_empty;
  assign o_inst       = fifo_rdata.inst;
  assign o_inst_pc    = fifo_rdata.pc;

  assign pcq_wdata  = '{pc: pc_q, inst: 32'h0};
  assign fifo_wdata = '{pc: pcq_rdata.pc, inst: i_imem_rdata};

  assign unused_ok = ^{fifo_full, pcq_full, pcq_empty, pcq_count, pcq_rdata.inst};

  // PCs of live (non-discarded) in-flight requests, oldest first
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_pc_queue (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_branch_taken),
    .i_push  (grant),
    .i_wdata (pcq_wdata),
    .i_pop   (resp_keep),
    .o_rdata (pcq_rdata),
    .o_full  (pcq_full),
    .o_empty (pcq_empty),
    .o_count (pcq_count)
  );

  // Returned instructions waiting for decode
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_inst_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_branch_taken),
    .i_push  (resp_keep && !i_branch_taken),
    .i_wdata (fifo_wdata),
    .i_pop   (pop),
    .o_rdata (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  // PC, in-flight and drop counters. On redirect every request still in
  // flight is wrong-path, including ones already marked for dropping, so
  // the new drop count is simply what remains outstanding.
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (i_branch_taken) begin
      pc_d          = redirect_pc;
      outstanding_d = outstanding_q - CW'(i_imem_rvalid);
      discard_d     = outstanding_q - CW'(i_imem_rvalid);
    end else begin
      if (grant) begin
        pc_d = rv32_next_pc(pc_q);
      end
      outstanding_d = outstanding_q + CW'(grant) - CW'(i_imem_rvalid);
      if (i_imem_rvalid && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
    end
  end

  // Fetch state registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q          <= RESET_VECTOR;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  rvalid_needs_outstanding : assert property (
    @(posedge i_clk) disable iff (!i_rst_n) i_imem_rvalid |-> (outstanding_q != '0)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a latency-programmable memory model
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        br_taken;
  logic [31:0] br_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fault;
  logic [31:0] fault_addr;

  fetch_unit #(.RESET_VECTOR(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_branch_taken (br_taken),
    .i_branch_addr  (br_addr),
    .o_imem_req     (imem_req),
    .o_imem_addr    (imem_addr),
    .i_imem_gnt     (imem_gnt),
    .i_imem_rvalid  (imem_rvalid),
    .i_imem_rdata   (imem_rdata),
    .o_inst_valid   (inst_valid),
    .i_inst_ready   (inst_ready),
    .o_inst         (inst),
    .o_inst_pc      (inst_pc),
    .o_fault        (fault),
    .o_fault_addr   (fault_addr)
  );

  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          mcyc = 0;
  int          gnt_budget = 0;
  int          mem_lat = 1;
  int          first_v, last_v, nv, c0;
  logic [31:0] exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d outputs pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pend_addr.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n < 200) passes++;
    else $display("FAIL %s_drain: %0d outputs still expected after %0d cycles", name, exp_q.size(), n);
    repeat (3) @(negedge clk);
  endtask

  // Memory model: grants while budget remains, answers in order after mem_lat cycles
  initial begin : mem_model
    logic [31:0] a;
    int          d;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        pend_addr.delete();
        pend_due.delete();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        imem_gnt    = 1'b0;
      end else begin
        if (pend_due.size() != 0 && pend_due[0] <= mcyc) begin
          a = pend_addr.pop_front();
          d = pend_due.pop_front();
          imem_rvalid = 1'b1;
          imem_rdata  = inst_of(a);
        end else begin
          imem_rvalid = 1'b0;
          imem_rdata  = '0;
        end
        imem_gnt = (gnt_budget > 0);
      end
      #3;
      if (rst_n && imem_req && imem_gnt) begin
        pend_addr.push_back(imem_addr);
        pend_due.push_back(mcyc + mem_lat);
        gnt_budget--;
      end
      mcyc++;
    end
  end

  // Monitor: every accepted head is compared against the oldest expectation
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_output: got pc 0x%08h inst 0x%08h, none expected", inst_pc, inst);
        end else begin
          e = exp_q.pop_front();
          check("out_pc", inst_pc, e);
          check("out_inst", inst, inst_of(e));
        end
      end
    end
  end

  initial begin : stim
    rst_n      = 1'b0;
    br_taken   = 1'b0;
    br_addr    = '0;
    inst_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(inst_valid), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_fault_addr", fault_addr, 32'h0);

    // Streaming: 1-cycle memory, decode always ready
    inst_ready = 1'b1;
    mem_lat    = 1;
    gnt_budget = 6;
    exp_q.push_back(32'h00); exp_q.push_back(32'h04); exp_q.push_back(32'h08);
    exp_q.push_back(32'h0C); exp_q.push_back(32'h10); exp_q.push_back(32'h14);
    rst_n = 1'b1;
    c0 = cyc;
    #2;
    check("req_after_reset", 32'(imem_req), 32'h1);
    first_v = -1; last_v = -1; nv = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (inst_valid) begin
        if (first_v < 0) first_v = cyc - c0;
        last_v = cyc - c0;
        nv++;
      end
    end
    check("first_valid_latency", 32'(first_v), 32'd2);
    check("stream_span", 32'(last_v - first_v), 32'd5);
    check("stream_count", 32'(nv), 32'd6);
    drain("stream");

    // Decode stalls: requests stop after two grants, resume without loss
    inst_ready = 1'b0;
    gnt_budget = 4;
    exp_q.push_back(32'h18); exp_q.push_back(32'h1C);
    exp_q.push_back(32'h20); exp_q.push_back(32'h24);
    repeat (4) @(negedge clk);
    #2;
    check("stall_req", 32'(imem_req), 32'h0);
    check("stall_grants_left", 32'(gnt_budget), 32'd2);
    check("stall_head_pc", inst_pc, 32'h18);
    inst_ready = 1'b1;
    drain("stall");

    // Redirect with two requests in flight
    mem_lat    = 3;
    gnt_budget = 2;
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    repeat (2) @(negedge clk);
    check("outstanding_before_redirect", 32'(dut.outstanding_q), 32'd2);
    br_taken   = 1'b1;
    br_addr    = 32'h100;
    gnt_budget = 3;
    #2;
    check("req_during_redirect", 32'(imem_req), 32'h0);
    @(negedge clk);
    br_taken = 1'b0;
    check("redirect_valid_b1", 32'(inst_valid), 32'h0);
    check("redirect_addr_b1", imem_addr, 32'h100);
    check("redirect_discard_b1", 32'(dut.discard_q), 32'd2);
    drain("redirect_outstanding");
    mem_lat = 1;

    // Redirect coinciding with a response and a pop
    gnt_budget = 2;
    exp_q.push_back(32'h10C);
    repeat (2) @(negedge clk);
    check("collide_head_valid", 32'(inst_valid), 32'h1);
    check("collide_head_pc", inst_pc, 32'h10C);
    br_taken   = 1'b1;
    br_addr    = 32'h200;
    gnt_budget = 2;
    exp_q.push_back(32'h200); exp_q.push_back(32'h204);
    @(negedge clk);
    br_taken = 1'b0;
    check("collide_valid_b1", 32'(inst_valid), 32'h0);
    check("collide_discard_b1", 32'(dut.discard_q), 32'd0);
    check("collide_outstanding_b1", 32'(dut.outstanding_q), 32'd0);
    check("collide_addr_b1", imem_addr, 32'h200);
    drain("redirect_collide");

    // Misaligned redirect target
    br_taken = 1'b1;
    br_addr  = 32'h102;
    @(negedge clk);
    br_taken = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    check("misalign_fault", 32'(fault), 32'h1);
    check("misalign_fault_addr", fault_addr, 32'h102);
    gnt_budget = 2;
    repeat (2) @(negedge clk);
    #2;
    check("misalign_req", 32'(imem_req), 32'h0);
    check("misalign_no_grant", 32'(gnt_budget), 32'd2);
    br_taken = 1'b1;
    br_addr  = 32'h100;
    @(negedge clk);
    br_taken = 1'b0;
    check("misalign_fault_cleared", 32'(fault), 32'h0);
`else
    check("misalign_addr", imem_addr, 32'h100);
    check("misalign_fault", 32'(fault), 32'h0);
    check("misalign_fault_addr", fault_addr, 32'h0);
    gnt_budget = 2;
`endif
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    drain("misalign");

    // PC wrap at the top of the address space
    br_taken   = 1'b1;
    br_addr    = 32'hFFFF_FFFC;
    gnt_budget = 2;
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0000_0000);
    @(negedge clk);
    br_taken = 1'b0;
    check("wrap_addr_before", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_addr_after", imem_addr, 32'h0000_0000);
    drain("wrap");

    // Reset while instructions are buffered
    inst_ready = 1'b0;
    gnt_budget = 2;
    repeat (3) @(negedge clk);
    check("pre_reset_valid", 32'(inst_valid), 32'h1);
    gnt_budget = 0;
    rst_n      = 1'b0;
    #2;
    check("midreset_valid", 32'(inst_valid), 32'h0);
    check("midreset_addr", imem_addr, 32'h0);
    check("midreset_outstanding", 32'(dut.outstanding_q), 32'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    inst_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_valid", 32'(inst_valid), 32'h0);
    check("post_reset_addr", imem_addr, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
